writeback_cycle: RTL and testbench
==================================

WRITEBACK_CYCLE -- requirements
Module: writeback_cycle

Interface
REQ-001 SHALL have parameter: WIDTH, 16, data/PC/immediate width.
REQ-002 SHALL have parameter: MEMTIMEOUT, 16, maximum cycles a load may wait for memvalid before being dropped.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- valid_in  in  1  upstream instruction valid.
- aluout  in  WIDTH  ALU result.
- memdata  in  WIDTH  load data; sampled live while a load is held.
- memvalid  in  1  memdata valid this cycle.
- pc  in  WIDTH  instruction PC.
- imm  in  WIDTH  immediate.
- rd  in  4  destination register.
- regwrite_in  in  1  instruction writes rd.
- wbsel  in  2  source select: 00 aluout, 01 memdata, 10 pc+2, 11 imm.
- writedata  out  WIDTH  value to the register file (the decode stage's writedata).
- regwrite  out  1  register-file write enable (the decode stage's regwrite).
- rdout  out  4  register-file write address.
- stall  out  1  upstream SHALL hold all inputs steady while this is high.
- retired  out  16  count of completed instructions.
- memerr  out  1  sticky load-timeout flag.

Function
REQ-005 The block SHALL hold a WB register (aluout, pc, imm, rd, regwrite_in, wbsel) and a two-state FSM: EMPTY and ACTIVE.
REQ-006 In EMPTY, the block SHALL drive regwrite=0, stall=0, writedata=0, and rdout=0.
REQ-007 In EMPTY with valid_in=1, the block SHALL load the WB register and go to ACTIVE at the edge.
REQ-008 In EMPTY with valid_in=0, the block SHALL stay in EMPTY.
REQ-009 In ACTIVE, the block SHALL drive rdout from the WB register.
REQ-010 In ACTIVE, writedata SHALL be combinational from the WB register and wbsel: 00 aluout, 01 live memdata, 10 pc+2 (mod 2^WIDTH), 11 imm.
REQ-011 ACTIVE SHALL be "ready" when wbsel!=01 or memvalid=1.
REQ-012 When ready, regwrite SHALL equal the latched regwrite_in AND (rd!=0); writes to r0 are always suppressed.
REQ-013 When ready, at the edge: retired SHALL increment by 1, wrapping 0xFFFF to 0x0000, whether or not regwrite was asserted.
REQ-014 When ready, at the edge: if valid_in=1, the block SHALL load the next instruction and stay ACTIVE (back-to-back, one instruction per cycle); otherwise it SHALL go to EMPTY.
REQ-015 When not ready (load with memvalid=0), the block SHALL drive stall=1 and regwrite=0, hold the WB register, ignore valid_in, and increment a wait counter.
REQ-016 The wait counter SHALL clear whenever a new instruction is loaded.
REQ-017 On the MEMTIMEOUT-th consecutive not-ready cycle, at the edge: the instruction SHALL be dropped (no write, retired unchanged), memerr SHALL be set, the wait counter SHALL clear, and the FSM SHALL go to EMPTY.
REQ-018 stall SHALL remain 1 during that final timeout cycle.
REQ-019 Once set, memerr SHALL stay 1 until rst.
REQ-020 stall SHALL be combinational: stall = ACTIVE AND wbsel==01 AND !memvalid.
REQ-021 Latency SHALL be one cycle: an instruction presented with valid_in=1 at edge N drives regwrite/writedata in the cycle after edge N (longer only for a waiting load).
REQ-022 If memvalid and valid_in rise in the same cycle as a waiting load, the load SHALL complete and the new instruction SHALL be loaded at that same edge.

Reset
REQ-023 rst=1 at an edge SHALL force: FSM to EMPTY, WB register to 0, wait counter to 0, retired to 0, memerr to 0.
REQ-024 Reset SHALL take priority over all other events.
REQ-025 Reset mid-stall SHALL drop the held instruction with no write and no retire.
REQ-026 In the cycle after reset: regwrite=0, stall=0, writedata=0, rdout=0.

Verification
REQ-027 ALU op: valid_in=1, rd=6, aluout=0x1234, wbsel=00, regwrite_in=1 -> next cycle regwrite=1, rdout=6, writedata=0x1234; retired becomes 1.
REQ-028 r0 guard: rd=0, regwrite_in=1, aluout=0xFFFF -> regwrite=0; retired still increments.
REQ-029 Load wait: wbsel=01, rd=3, memvalid low 3 cycles then memdata=0x00AB with memvalid=1 -> stall=1 and regwrite=0 for 3 cycles, then regwrite=1, rdout=3, writedata=0x00AB, stall=0.
REQ-030 Link and imm: wbsel=10, pc=0xFFFE -> writedata=0x0000; wbsel=11, imm=0x0042 -> writedata=0x0042; back-to-back with no bubble.
REQ-031 Timeout: load with memvalid held 0 -> stall=1 for 16 cycles, no write, memerr=1 thereafter, FSM EMPTY, retired unchanged.
REQ-032 Reset mid-stall and wrap: assert rst during a load wait -> regwrite never pulses and all outputs are 0; separately, 65536 retired instructions -> retired=0x0000.

Source files
------------

// File: rtl/writeback_cycle_if.sv
// Writeback-stage bus: the upstream instruction fields in, the register-file write
// port and the status outputs back.
`timescale 1ns/1ps
interface writeback_cycle_if #(
    parameter int WIDTH = 16
);
    logic             valid_in;
    logic [WIDTH-1:0] aluout;
    logic [WIDTH-1:0] memdata;
    logic             memvalid;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] imm;
    logic [3:0]       rd;
    logic             regwrite_in;
    logic [1:0]       wbsel;
    logic [WIDTH-1:0] writedata;
    logic             regwrite;
    logic [3:0]       rdout;
    logic             stall;
    logic [15:0]      retired;
    logic             memerr;

    modport master (
        output valid_in, aluout, memdata, memvalid, pc, imm, rd, regwrite_in, wbsel,
        input  writedata, regwrite, rdout, stall, retired, memerr
    );

    modport slave (
        input  valid_in, aluout, memdata, memvalid, pc, imm, rd, regwrite_in, wbsel,
        output writedata, regwrite, rdout, stall, retired, memerr
    );
endinterface

// File: rtl/writeback_cycle.sv
// Writeback stage: one instruction register, EMPTY/ACTIVE control, load wait with
// timeout, retired-instruction counter and a sticky load-timeout flag.
`timescale 1ns/1ps
module writeback_cycle #(
    parameter int WIDTH      = 16,
    parameter int MEMTIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    writeback_cycle_if.slave   bus
);
    localparam int WAITW = $clog2(MEMTIMEOUT + 1);
    localparam logic [WAITW-1:0] WAIT_LAST = WAITW'(MEMTIMEOUT - 1);

    typedef enum logic {
        EMPTY  = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] aluout_reg;
    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] imm_reg;
    logic [3:0]       rd_reg;
    logic             regwrite_reg;
    logic [1:0]       wbsel_reg;
    logic [WAITW-1:0] wait_cnt_reg;
    logic [15:0]      retired_reg;
    logic             memerr_reg;

    logic             active;
    logic             ready;
    logic             not_ready;
    logic             timeout_hit;
    logic             load_en;
    logic [WIDTH-1:0] pc_plus2;
    logic [3:0]       sel_onehot;
    logic [WIDTH-1:0] src [4];
    logic [WIDTH-1:0] writedata_mux;

    assign active      = (state_reg == ACTIVE);
    // A held load is the only thing that can make the stage wait.
    assign ready       = active && ((wbsel_reg != 2'b01) || bus.memvalid);
    assign not_ready   = active && (wbsel_reg == 2'b01) && !bus.memvalid;
    assign timeout_hit = not_ready && (wait_cnt_reg == WAIT_LAST);
    assign load_en     = bus.valid_in && ((state_reg == EMPTY) || ready);

    assign pc_plus2    = pc_reg + WIDTH'(2);
    assign sel_onehot  = 4'b0001 << wbsel_reg;
    assign src[0]      = aluout_reg;
    assign src[1]      = bus.memdata;
    assign src[2]      = pc_plus2;
    assign src[3]      = imm_reg;

    // Bitwise AND-OR source mux; memdata is taken live, not from a register.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_wd_bit
            assign writedata_mux[gi] = |({src[3][gi], src[2][gi], src[1][gi], src[0][gi]} & sel_onehot);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= EMPTY;
            aluout_reg   <= '0;
            pc_reg       <= '0;
            imm_reg      <= '0;
            rd_reg       <= '0;
            regwrite_reg <= 1'b0;
            wbsel_reg    <= '0;
            wait_cnt_reg <= '0;
            retired_reg  <= '0;
            memerr_reg   <= 1'b0;
        end else begin
            if (load_en) begin
                aluout_reg   <= bus.aluout;
                pc_reg       <= bus.pc;
                imm_reg      <= bus.imm;
                rd_reg       <= bus.rd;
                regwrite_reg <= bus.regwrite_in;
                wbsel_reg    <= bus.wbsel;
            end
            case (state_reg)
                EMPTY: begin
                    wait_cnt_reg <= '0;
                    if (bus.valid_in) begin
                        state_reg <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (ready) begin
                        retired_reg  <= retired_reg + 16'd1;
                        wait_cnt_reg <= '0;
                        state_reg    <= bus.valid_in ? ACTIVE : EMPTY;
                    end else if (timeout_hit) begin
                        // Load gave up: drop it without a write or a retire.
                        memerr_reg   <= 1'b1;
                        wait_cnt_reg <= '0;
                        state_reg    <= EMPTY;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= EMPTY;
                end
            endcase
        end
    end

    assign bus.writedata = active ? writedata_mux : '0;
    assign bus.rdout     = active ? rd_reg : 4'd0;
    assign bus.regwrite  = ready && regwrite_reg && (rd_reg != 4'd0);
    assign bus.stall     = not_ready;
    assign bus.retired   = retired_reg;
    assign bus.memerr    = memerr_reg;
endmodule

// File: tb/tb_writeback_cycle.sv
// Randomized scoreboard bench for writeback_cycle: the driver pushes the expected
// writeback of every accepted instruction, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_writeback_cycle;
    localparam int WIDTH = 16;
    localparam int MT    = 16;

    typedef struct {
        logic [15:0] alu;
        logic [15:0] pc;
        logic [15:0] imm;
        logic [15:0] md;
        logic [3:0]  rd;
        logic        we;
        logic [1:0]  sel;
        int          waits;
        int          gap;
    } instr_t;

    typedef struct {
        bit          timeout;
        int          stalls;
        logic        we;
        logic [3:0]  rd;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    writeback_cycle_if #(.WIDTH(WIDTH)) bus();
    writeback_cycle #(.WIDTH(WIDTH), .MEMTIMEOUT(MT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    instr_t stim_q[$];
    exp_t   exp_q[$];
    int     checks  = 0;
    int     errors  = 0;
    bit     verbose = 1'b1;

    logic [15:0] exp_retired = '0;
    logic        exp_memerr  = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Expected writeback derived from the instruction and the plan for its load.
    function automatic exp_t make_exp(instr_t i);
        exp_t e;
        e.timeout = (i.sel == 2'b01) && (i.waits >= MT);
        e.stalls  = (i.sel != 2'b01) ? 0 : (e.timeout ? MT : i.waits);
        e.we      = i.we && (i.rd != 4'd0);
        e.rd      = i.rd;
        case (i.sel)
            2'b00:   e.data = i.alu;
            2'b01:   e.data = i.md;
            2'b10:   e.data = 16'(i.pc + 16'd2);
            default: e.data = i.imm;
        endcase
        return e;
    endfunction

    function automatic instr_t mk(logic [1:0] sel, logic [3:0] rd, logic we, logic [15:0] alu,
                                  logic [15:0] pc, logic [15:0] imm, logic [15:0] md,
                                  int waits, int gap);
        instr_t i;
        i.sel = sel; i.rd = rd; i.we = we; i.alu = alu; i.pc = pc; i.imm = imm;
        i.md = md; i.waits = waits; i.gap = gap;
        return i;
    endfunction

    function automatic instr_t rand_instr(bit allow_load);
        instr_t i;
        int r;
        i = mk(2'($urandom_range(0, 3)), 4'($urandom), 1'($urandom), 16'($urandom),
               16'($urandom), 16'($urandom), 16'($urandom), 0, 0);
        if (!allow_load && i.sel == 2'b01) i.sel = 2'b00;
        r = $urandom_range(0, 19);
        i.waits = (r == 0) ? MT + $urandom_range(0, 3) : $urandom_range(0, 4);
        i.gap   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
        if (!allow_load) i.gap = 0;
        return i;
    endfunction

    // Cycle-level upstream model: presents stim_q, drives memvalid for the held load.
    task automatic run_stim(input int budget);
        instr_t wb, pend;
        bit have_wb = 1'b0, have_pend = 1'b0, wb_stall, present;
        int stalled = 0, gap_left = 0, cycles = 0;
        while (1) begin
            if (!have_pend && stim_q.size() > 0) begin
                pend = stim_q.pop_front();
                have_pend = 1'b1;
                gap_left = pend.gap;
            end
            if (!have_pend && !have_wb) break;
            if (cycles >= budget) begin
                checks++; errors++;
                $display("FAIL run_stim_budget: got %0d cycles, expected fewer than %0d", cycles, budget);
                break;
            end
            present  = have_pend && (gap_left == 0);
            wb_stall = have_wb && (wb.sel == 2'b01) && (stalled < wb.waits);
            bus.valid_in    = present;
            bus.aluout      = present ? pend.alu : 16'($urandom);
            bus.pc          = present ? pend.pc  : 16'($urandom);
            bus.imm         = present ? pend.imm : 16'($urandom);
            bus.rd          = present ? pend.rd  : 4'($urandom);
            bus.regwrite_in = present ? pend.we  : 1'($urandom);
            bus.wbsel       = present ? pend.sel : 2'($urandom);
            if (have_wb && wb.sel == 2'b01) begin
                bus.memvalid = !wb_stall;
                bus.memdata  = wb_stall ? 16'($urandom) : wb.md;
            end else begin
                bus.memvalid = 1'($urandom);
                bus.memdata  = 16'($urandom);
            end
            @(posedge clk); #1;
            cycles++;
            if (wb_stall) begin
                if (stalled + 1 == MT) begin
                    have_wb = 1'b0;
                    stalled = 0;
                end else begin
                    stalled++;
                end
            end else begin
                have_wb = 1'b0;
            end
            if (present && !wb_stall) begin
                exp_q.push_back(make_exp(pend));
                wb = pend;
                have_wb = 1'b1;
                stalled = 0;
                have_pend = 1'b0;
            end else if (have_pend && gap_left > 0) begin
                gap_left--;
            end
        end
        bus.valid_in = 1'b0;
        bus.memvalid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: a retired step marks the previous cycle as a completion; a stall run
    // that ends without one marks a timeout.
    bit          mon_resync = 1'b1;
    bit          mon_cand   = 1'b0;
    int          cur_stalls = 0;
    logic        p_rw       = 1'b0;
    logic        p_stall    = 1'b0;
    logic [3:0]  p_rd       = '0;
    logic [15:0] p_wd       = '0;
    logic [15:0] p_ret      = '0;
    exp_t        mon_e;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_resync = 1'b1; mon_cand = 1'b0; cur_stalls = 0;
                exp_retired = '0; exp_memerr = 1'b0;
            end else if (mon_resync) begin
                mon_resync = 1'b0;
            end else begin
                if (bus.retired != p_ret) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_retire: got retired=%0h, expected no retire", bus.retired);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.timeout) begin
                            checks++; errors++;
                            $display("FAIL retire_of_timed_out_load: got retired=%0h, expected drop", bus.retired);
                        end else begin
                            exp_retired = exp_retired + 16'd1;
                            chk("retired", 32'(bus.retired), 32'(exp_retired));
                            chk("regwrite", 32'(p_rw), 32'(mon_e.we));
                            chk("rdout", 32'(p_rd), 32'(mon_e.rd));
                            chk("writedata", 32'(p_wd), 32'(mon_e.data));
                            chk("stall_cycles", 32'(cur_stalls), 32'(mon_e.stalls));
                            if (verbose)
                                $display("[%0t] retire rd=%0d we=%0b data=%04h stalls=%0d retired=%0d",
                                         $time, p_rd, p_rw, p_wd, cur_stalls, bus.retired);
                        end
                    end
                    mon_cand = 1'b0; cur_stalls = 0;
                end else if (mon_cand) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_drop: got stall run of %0d, expected none", cur_stalls);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (!mon_e.timeout) begin
                            checks++; errors++;
                            $display("FAIL missing_retire: got no retire, expected rd=%0d data=%04h", mon_e.rd, mon_e.data);
                        end else begin
                            exp_memerr = 1'b1;
                            chk("timeout_stall_cycles", 32'(cur_stalls), 32'(MT));
                            chk("memerr_after_timeout", 32'(bus.memerr), 32'(exp_memerr));
                            chk("retired_after_timeout", 32'(bus.retired), 32'(exp_retired));
                            if (verbose)
                                $display("[%0t] timeout stalls=%0d memerr=%0b retired=%0d",
                                         $time, cur_stalls, bus.memerr, bus.retired);
                        end
                    end
                    mon_cand = 1'b0; cur_stalls = 0;
                end
                mon_cand = p_stall && !bus.stall;
                if (bus.stall) begin
                    cur_stalls++;
                    chk("regwrite_during_stall", 32'(bus.regwrite), 32'(0));
                end
            end
            p_rw = bus.regwrite; p_rd = bus.rdout; p_wd = bus.writedata;
            p_ret = bus.retired; p_stall = bus.stall;
        end
    end

    task automatic check_idle(string tag);
        chk({tag, "_regwrite"},  32'(bus.regwrite),  32'(0));
        chk({tag, "_stall"},     32'(bus.stall),     32'(0));
        chk({tag, "_writedata"}, 32'(bus.writedata), 32'(0));
        chk({tag, "_rdout"},     32'(bus.rdout),     32'(0));
        chk({tag, "_retired"},   32'(bus.retired),   32'(0));
        chk({tag, "_memerr"},    32'(bus.memerr),    32'(0));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish, expected end within 3 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.valid_in = 1'b0; bus.aluout = '0; bus.memdata = '0; bus.memvalid = 1'b0;
        bus.pc = '0; bus.imm = '0; bus.rd = '0; bus.regwrite_in = 1'b0; bus.wbsel = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_idle("reset");

        // Directed: ALU op, r0 guard, waited load, link/imm back-to-back, timeout.
        stim_q.push_back(mk(2'b00, 4'd6, 1'b1, 16'h1234, 16'h0, 16'h0, 16'h0, 0, 0));
        stim_q.push_back(mk(2'b00, 4'd0, 1'b1, 16'hFFFF, 16'h0, 16'h0, 16'h0, 0, 0));
        stim_q.push_back(mk(2'b01, 4'd3, 1'b1, 16'h0, 16'h0, 16'h0, 16'h00AB, 3, 0));
        stim_q.push_back(mk(2'b10, 4'd5, 1'b1, 16'h0, 16'hFFFE, 16'h0, 16'h0, 0, 0));
        stim_q.push_back(mk(2'b11, 4'd7, 1'b1, 16'h0, 16'h0, 16'h0042, 16'h0, 0, 0));
        stim_q.push_back(mk(2'b01, 4'd9, 1'b1, 16'h0, 16'h0, 16'h0, 16'h5555, MT, 2));
        run_stim(200);
        chk("memerr_sticky", 32'(bus.memerr), 32'(1));
        chk("retired_directed", 32'(bus.retired), 32'(5));

        for (int n = 0; n < 300; n++) stim_q.push_back(rand_instr(1'b1));
        run_stim(20000);
        chk("queue_drained_random", 32'(exp_q.size()), 32'(0));

        // Reset in the middle of a load wait drops it silently.
        bus.valid_in = 1'b1; bus.wbsel = 2'b01; bus.rd = 4'd4; bus.regwrite_in = 1'b1;
        bus.memvalid = 1'b0;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("midstall_stall", 32'(bus.stall), 32'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("midstall_reset");

        // 65536 single-cycle instructions wrap the retired counter back to zero.
        verbose = 1'b0;
        for (int n = 0; n < 65536; n++) stim_q.push_back(rand_instr(1'b0));
        run_stim(70000);
        chk("retired_wrap", 32'(bus.retired), 32'(0));
        chk("queue_drained_wrap", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
